// File: rtl/fc_pkg.sv
// Shared fully connected layer helpers: accumulator width, requant shift
// width and signed saturation bounds for an N-bit activation.
package fc_pkg;

    function automatic int acc_w(input int n, input int k);
        return 2 * n + k - 1;
    endfunction

    function automatic int shift_w(input int n, input int k);
        return $clog2(acc_w(n, k));
    endfunction

    function automatic longint sat_max(input int n);
        return (longint'(1) <<< (n - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int n);
        return -(longint'(1) <<< (n - 1));
    endfunction

endpackage

// File: rtl/sat_clip.sv
// Combinational signed clamp of an IW-bit value to OW bits.
// Ports: r_i value in, clip_o clamped value, sat_o set when clamped.
module sat_clip
    import fc_pkg::*;
#(
    parameter int IW = 19,
    parameter int OW = 8
) (
    input  logic signed [IW-1:0] r_i,
    output logic signed [OW-1:0] clip_o,
    output logic                 sat_o
);

    localparam logic signed [IW-1:0] HI = IW'(sat_max(OW));
    localparam logic signed [IW-1:0] LO = IW'(sat_min(OW));

    always_comb begin
        clip_o = r_i[OW-1:0];
        sat_o  = 1'b0;
        if (r_i > HI) begin
            clip_o = HI[OW-1:0];
            sat_o  = 1'b1;
        end else if (r_i < LO) begin
            clip_o = LO[OW-1:0];
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/mac_requant.sv
// Two-stage requantizer: round + arithmetic shift, then saturate (optional
// ReLU when MAC_REQUANT_RELU_EN is defined). Valid/ready on both sides,
// frame of M words with o_last on the final one; shift latched per frame.
// Ports: clk, rst_n, i_data/i_valid/i_ready/i_shift in,
//        o_data/o_valid/o_ready/o_last/o_sat out.
module mac_requant
    import fc_pkg::*;
#(
    parameter int  N  = 8,
    parameter int  K  = 3,
    parameter int  M  = 4,
    localparam int W  = acc_w(N, K),
    localparam int SW = shift_w(N, K)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  i_data,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [SW-1:0] i_shift,
    output logic [N-1:0]  o_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic          o_last,
    output logic          o_sat
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SW-1:0]       shift_q, shift_d;
    logic [SW-1:0]       sh;
    logic                s1_valid_q;
    logic signed [W:0]   s1_r_q;
    logic                s1_last_q;
    logic                o_valid_q;
    logic [N-1:0]        o_data_q;
    logic                o_last_q;
    logic                o_sat_q;

    logic                s1_en, s2_en, acc;
    logic                last_d;
    logic signed [W:0]   t, rnd, r_d;
    logic signed [N-1:0] clip, res;
    logic                sat;

    assign s2_en   = !o_valid_q || o_ready;
    assign s1_en   = !s1_valid_q || s2_en;
    assign i_ready = s1_en;
    assign acc     = i_valid && s1_en;

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_last  = o_last_q;
    assign o_sat   = o_sat_q;

    // First word of a frame uses the live shift; the rest use the latch.
    always_comb begin
        sh      = (cnt_q == '0) ? i_shift : shift_q;
        last_d  = (cnt_q == CW'(M - 1));
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (acc) begin
            cnt_d = last_d ? '0 : cnt_q + CW'(1);
            if (cnt_q == '0) shift_d = i_shift;
        end
    end

    // One extra bit keeps the half-LSB rounding add from overflowing.
    always_comb begin
        t   = $signed({i_data[W-1], i_data});
        rnd = '0;
        if (sh != '0) rnd = (W + 1)'(1) << (sh - SW'(1));
        r_d = (t + rnd) >>> sh;
    end

    sat_clip #(
        .IW(W + 1),
        .OW(N)
    ) u_sat_clip (
        .r_i   (s1_r_q),
        .clip_o(clip),
        .sat_o (sat)
    );

    always_comb begin
        res = clip;
`ifdef MAC_REQUANT_RELU_EN
        if (clip[N-1]) res = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_r_q     <= '0;
            s1_last_q  <= 1'b0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_last_q   <= 1'b0;
            o_sat_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            if (s1_en) begin
                s1_valid_q <= i_valid;
                if (i_valid) begin
                    s1_r_q    <= r_d;
                    s1_last_q <= last_d;
                end
            end
            if (s2_en) begin
                o_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    o_data_q <= res;
                    o_last_q <= s1_last_q;
                    o_sat_q  <= sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_requant.sv
// Scoreboard bench for mac_requant: reference arithmetic model, frame model,
// latency, backpressure, framing and mid-frame reset.
module tb_mac_requant;
    import fc_pkg::*;

    localparam int N  = 8;
    localparam int K  = 3;
    localparam int M  = 4;
    localparam int W  = acc_w(N, K);
    localparam int SW = shift_w(N, K);

    typedef struct {
        longint data;
        bit     last;
        bit     sat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  i_data;
    logic          i_valid;
    logic          i_ready;
    logic [SW-1:0] i_shift;
    logic [N-1:0]  o_data;
    logic          o_valid;
    logic          o_ready;
    logic          o_last;
    logic          o_sat;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   mcnt     = 0;
    int   mshift   = 0;
    int   n_acc    = 0;

    mac_requant #(.N(N), .K(K), .M(M)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (i_data),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .i_shift(i_shift),
        .o_data (o_data),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o_last (o_last),
        .o_sat  (o_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint model(input longint d, input int sh, output bit sat);
        longint t, r, hi, lo;
        hi  = (longint'(1) <<< (N - 1)) - 1;
        lo  = -(longint'(1) <<< (N - 1));
        t   = d + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : 0);
        r   = t >>> sh;
        sat = 1'b0;
        if (r > hi) begin
            r = hi;
            sat = 1'b1;
        end else if (r < lo) begin
            r = lo;
            sat = 1'b1;
        end
`ifdef MAC_REQUANT_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    task automatic push(input longint d, input int sh);
        exp_t e;
        int   eff;
        eff = (mcnt == 0) ? sh : mshift;
        if (mcnt == 0) mshift = sh;
        e.data = model(d, eff, e.sat);
        e.last = (mcnt == M - 1);
        mcnt   = (mcnt + 1) % M;
        n_acc++;
        sb.push_back(e);
    endtask

    task automatic send(input longint d, input int sh, input int budget, output bit ok);
        ok      = 1'b0;
        i_valid = 1'b1;
        i_data  = d[W-1:0];
        i_shift = SW'(sh);
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (i_ready) begin
                push(d, sh);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (ok) i_valid = 1'b0;
    endtask

    task automatic put(input string tag, input longint d, input int sh);
        bit ok;
        send(d, sh, 20, ok);
        check(tag, ok, 1);
    endtask

    task automatic drain();
        o_ready = 1'b1;
        for (int c = 0; c < 50 && sb.size() != 0; c++) @(posedge clk);
        check("drain", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && o_valid && o_ready) begin
            if (sb.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                check("data", longint'($signed(o_data)), e.data);
                check("last", o_last, e.last);
                check("sat", o_sat, e.sat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        longint fr[8];
        bit     ok;
        int     a0;
        fr = '{100, -100, 55, -55, 1000, -1001, 7, -9};
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_shift = '0;
        o_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_ovalid", o_valid, 0);
        check("rst_odata", o_data, 0);
        check("rst_olast", o_last, 0);
        check("rst_osat", o_sat, 0);
        check("rst_iready", i_ready, 1);

        put("acc_up", 1000, 7);
        check("lat_c1", o_valid, 0);
        @(posedge clk);
        #1;
        check("lat_c2", o_valid, 1);
        check("roundup", longint'($signed(o_data)), 8);
        check("roundup_sat", o_sat, 0);
        put("acc_neg", -1000, 7);
        put("acc_zero", 0, 7);
        put("acc_big", 131071, 7);
        drain();

        put("acc_s0", 131071, 0);
        put("acc_s1", -131072, 0);
        put("acc_s2", 5, 0);
        put("acc_s3", -5, 0);
        drain();

        o_ready = 1'b0;
        a0 = n_acc;
        put("bp_w0", 300, 3);
        put("bp_w1", -300, 3);
        send(77, 3, 4, ok);
        check("bp_blocked", ok, 0);
        check("bp_iready", i_ready, 0);
        check("bp_count", n_acc - a0, 2);
        o_ready = 1'b1;
        put("bp_w2", 77, 3);
        put("bp_w3", -77, 3);
        drain();

        for (int i = 0; i < 8; i++) put("frm", fr[i], (i < 2) ? 4 : 2);
        drain();

        o_ready = 1'b0;
        put("rs_w0", 40, 3);
        put("rs_w1", 41, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ovalid", o_valid, 0);
        sb.delete();
        mcnt = 0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        o_ready = 1'b1;
        put("rs_n0", 200, 1);
        put("rs_n1", 201, 5);
        put("rs_n2", 202, 6);
        put("rs_n3", 203, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
